// File: rtl/spi_reg_if.sv
// Pin-side SPI signals plus the register-file request bundle.
interface spi_reg_if #(
   parameter int ADDR_SPACE_BITS = 8
);
   logic                       ss;
   logic                       sck;
   logic                       mosi;
   logic                       miso;
   logic [ADDR_SPACE_BITS-1:0] reg_addr;
   logic                       write;
   logic                       new_req;
   logic [7:0]                 write_value;
   logic [7:0]                 read_value;
   logic                       in_transaction;

   modport slave (
      input  ss, sck, mosi, read_value,
      output miso, reg_addr, write, new_req,
      output write_value, in_transaction
   );

   modport master (
      output ss, sck, mosi, read_value,
      input  miso, reg_addr, write, new_req,
      input  write_value, in_transaction
   );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave turning pin traffic into byte register requests.
// Optional SPI_WRITE_ECHO_EN: write data bytes echo the previous byte on miso.
module spi_reg_slave #(
   parameter int ADDR_SPACE      = 256,
   parameter int ADDR_SPACE_BITS = $clog2(ADDR_SPACE)
) (
   input logic      clk,
   input logic      rst,
   spi_reg_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA
   } state_t;

   localparam logic [ADDR_SPACE_BITS-1:0] LAST_ADDR =
      ADDR_SPACE_BITS'(ADDR_SPACE - 1);

   logic [1:0] r_ss_s, r_sck_s, r_mosi_s;
   logic       r_sck_d, r_ss_d, r_ss_ok;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_rx_sr;
   logic [7:0] r_rx_byte;
   logic       r_byte_done;
   logic [6:0] r_tx_sr;
   logic       r_miso, r_rd_p1;

   state_t                     r_state, w_state_nxt;
   logic                       r_write, w_write_nxt;
   logic                       r_inc, w_inc_nxt;
   logic                       r_inc_pend, w_inc_pend_nxt;
   logic [ADDR_SPACE_BITS-1:0] r_reg_addr, w_addr_nxt, w_addr_inc;
   logic                       r_new_req, w_req_nxt;
   logic [7:0]                 r_wval, w_wval_nxt;
   logic                       r_in_trans;
   logic                       w_load;
   logic [7:0]                 w_load_byte, w_echo;

   logic w_ss_hi, w_ss_fall, w_rise, w_fall;

   assign w_ss_hi   = r_ss_s[1];
   assign w_ss_fall = r_ss_d & ~r_ss_s[1];
   assign w_rise    = r_sck_s[1] & ~r_sck_d;
   assign w_fall    = ~r_sck_s[1] & r_sck_d;

   assign w_addr_inc = (r_reg_addr == LAST_ADDR) ? '0 : r_reg_addr + 1'b1;

`ifdef SPI_WRITE_ECHO_EN
   assign w_echo = r_rx_byte;
`else
   assign w_echo = 8'h00;
`endif

   // ss syncs reset low so a reset with ss held low cannot fake a falling edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ss_s   <= '0;
         r_sck_s  <= '0;
         r_mosi_s <= '0;
         r_sck_d  <= 1'b0;
         r_ss_d   <= 1'b0;
         r_ss_ok  <= 1'b0;
      end else begin
         r_ss_s   <= {r_ss_s[0], bus.ss};
         r_sck_s  <= {r_sck_s[0], bus.sck};
         r_mosi_s <= {r_mosi_s[0], bus.mosi};
         r_sck_d  <= r_sck_s[1];
         r_ss_d   <= r_ss_s[1];
         r_ss_ok  <= r_ss_ok | r_ss_s[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt   <= '0;
         r_rx_sr     <= '0;
         r_rx_byte   <= '0;
         r_byte_done <= 1'b0;
      end else if (w_ss_hi) begin
         r_bit_cnt   <= '0;
         r_rx_sr     <= '0;
         r_byte_done <= 1'b0;
      end else begin
         r_byte_done <= 1'b0;
         if (w_rise) begin
            r_rx_sr   <= {r_rx_sr[5:0], r_mosi_s[1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte_done <= 1'b1;
               r_rx_byte   <= {r_rx_sr, r_mosi_s[1]};
            end
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_write_nxt    = r_write;
      w_inc_nxt      = r_inc;
      w_addr_nxt     = r_reg_addr;
      w_req_nxt      = 1'b0;
      w_wval_nxt     = r_wval;
      w_inc_pend_nxt = 1'b0;
      w_load         = 1'b0;
      w_load_byte    = 8'h00;
      if (r_inc_pend) w_addr_nxt = w_addr_inc;
      if (w_ss_hi) begin
         w_state_nxt = S_IDLE;
         w_write_nxt = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_ss_fall) begin
               w_state_nxt = S_CMD;
               w_load      = 1'b1;
            end
            S_CMD: if (r_byte_done) begin
               w_state_nxt = S_ADDR;
               w_write_nxt = r_rx_byte[7];
               w_inc_nxt   = r_rx_byte[6];
               w_load      = 1'b1;
            end
            S_ADDR: if (r_byte_done) begin
               w_state_nxt = S_DATA;
               w_addr_nxt  = r_rx_byte[ADDR_SPACE_BITS-1:0];
               if (r_write) begin
                  w_load      = 1'b1;
                  w_load_byte = w_echo;
               end else begin
                  w_req_nxt = 1'b1;
               end
            end
            S_DATA: if (r_byte_done) begin
               w_req_nxt = 1'b1;
               if (r_write) begin
                  w_wval_nxt     = r_rx_byte;
                  w_inc_pend_nxt = r_inc;
                  w_load         = 1'b1;
                  w_load_byte    = w_echo;
               end else if (r_inc) begin
                  w_addr_nxt = w_addr_inc;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_inc      <= 1'b0;
         r_inc_pend <= 1'b0;
         r_reg_addr <= '0;
         r_new_req  <= 1'b0;
         r_wval     <= '0;
         r_in_trans <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_write    <= w_write_nxt;
         r_inc      <= w_inc_nxt;
         r_inc_pend <= w_inc_pend_nxt;
         r_reg_addr <= w_addr_nxt;
         r_new_req  <= w_req_nxt;
         r_wval     <= w_wval_nxt;
         r_in_trans <= ~w_ss_hi & r_ss_ok;
      end
   end

   // first falling edge of a byte is skipped: its MSB is already out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_sr <= '0;
         r_miso  <= 1'b0;
         r_rd_p1 <= 1'b0;
      end else begin
         r_rd_p1 <= r_new_req & ~r_write;
         if (w_ss_hi) begin
            r_tx_sr <= '0;
            r_miso  <= 1'b0;
         end else if (w_load) begin
            r_miso  <= w_load_byte[7];
            r_tx_sr <= w_load_byte[6:0];
         end else if (r_rd_p1) begin
            r_miso  <= bus.read_value[7];
            r_tx_sr <= bus.read_value[6:0];
         end else if (w_fall && r_bit_cnt != 3'd0) begin
            r_miso  <= r_tx_sr[6];
            r_tx_sr <= {r_tx_sr[5:0], 1'b0};
         end
      end
   end

   assign bus.miso           = r_miso;
   assign bus.reg_addr       = r_reg_addr;
   assign bus.write          = r_write;
   assign bus.new_req        = r_new_req;
   assign bus.write_value    = r_wval;
   assign bus.in_transaction = r_in_trans;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: SPI master driver, register-file stand-in,
// transaction-level model, request and miso scoreboards.
module tb_spi_reg_slave;
   localparam int HALF = 8;

`ifdef SPI_WRITE_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } req_t;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_reg_if #(.ADDR_SPACE_BITS(8)) bus ();

   spi_reg_slave dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   nreq  = 0;
   int   rx_n  = 0;
   logic [7:0] rx_sh = 8'h00;
   bit   chk_miso = 1'b1;
   logic [7:0] seed_b = 8'h00;

   req_t       exp_req[$];
   logic [7:0] exp_miso[$];
   logic [7:0] ref_mem[256];
   logic [7:0] rf[256];
   bit         rf_valid[256];

   function automatic logic [7:0] init_val(input logic [7:0] a);
      return a ^ seed_b ^ {a[3:0], a[7:4]};
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // register file stand-in: read data valid the cycle after new_req
   always @(posedge clk) begin
      if (bus.new_req) begin
         if (bus.write) begin
            rf[bus.reg_addr]       <= bus.write_value;
            rf_valid[bus.reg_addr] <= 1'b1;
         end else begin
            bus.read_value <= rf_valid[bus.reg_addr] ?
                              rf[bus.reg_addr] : init_val(bus.reg_addr);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus.new_req === 1'b1) begin
         req_t e;
         nreq++;
         if (exp_req.size() == 0) begin
            check("unexpected_req", {23'd0, bus.write, bus.reg_addr}, 32'hFFFF);
         end else begin
            e = exp_req.pop_front();
            check("req_write", {31'd0, bus.write}, {31'd0, e.wr});
            check("req_addr", {24'd0, bus.reg_addr}, {24'd0, e.addr});
            if (e.wr)
               check("req_data", {24'd0, bus.write_value}, {24'd0, e.data});
         end
      end
   end

   always @(posedge bus.sck) begin
      if (bus.ss === 1'b0 && chk_miso) begin
         rx_sh = {rx_sh[6:0], bus.miso};
         rx_n++;
         if (rx_n == 8) begin
            rx_n = 0;
            if (exp_miso.size() == 0)
               check("unexpected_miso", {24'd0, rx_sh}, 32'hFFFF);
            else
               check("miso_byte", {24'd0, rx_sh}, {24'd0, exp_miso.pop_front()});
         end
      end
   end

   always @(posedge bus.ss) rx_n = 0;

   // transaction-level view: cmd, addr, then data with optional increment
   function automatic void model(input bq_t b);
      int   n;
      logic wr, inc;
      logic [7:0] a;
      n = b.size();
      wr  = (n > 0) ? b[0][7] : 1'b0;
      inc = (n > 0) ? b[0][6] : 1'b0;
      for (int k = 0; k < n; k++) begin
         logic [7:0] m;
         m = 8'h00;
         if (k >= 2) begin
            if (wr) begin
               m = ECHO ? b[k-1] : 8'h00;
            end else begin
               a = 8'((int'(b[1]) + (k - 2) * int'(inc)) % 256);
               m = ref_mem[a];
            end
         end
         exp_miso.push_back(m);
      end
      if (n >= 2) begin
         if (wr) begin
            for (int k = 2; k < n; k++) begin
               a = 8'((int'(b[1]) + (k - 2) * int'(inc)) % 256);
               exp_req.push_back('{1'b1, a, b[k]});
               ref_mem[a] = b[k];
            end
         end else begin
            for (int k = 1; k < n; k++) begin
               a = 8'((int'(b[1]) + (k - 1) * int'(inc)) % 256);
               exp_req.push_back('{1'b0, a, 8'h00});
            end
         end
      end
   endfunction

   task automatic spi_byte(input logic [7:0] b, input int nbits);
      for (int i = 7; i >= 8 - nbits; i--) begin
         bus.mosi = b[i];
         repeat (HALF) @(negedge clk);
         bus.sck = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.sck = 1'b0;
      end
   endtask

   task automatic txn(input bq_t b, input int extra);
      int n;
      logic exp_w;
      model(b);
      exp_w = b[0][7];
      bus.ss = 1'b0;
      repeat (HALF) @(negedge clk);
      foreach (b[i]) spi_byte(b[i], 8);
      if (extra > 0) spi_byte(8'hA5, extra);
      repeat (HALF) @(negedge clk);
      bus.ss = 1'b1;
      n = 0;
      while (bus.in_transaction === 1'b1 && n < 10) begin
         check("write_hold", {31'd0, bus.write}, {31'd0, exp_w});
         @(negedge clk);
         n++;
      end
      check("in_trans_fall_lat", n, 3);
      check("write_clear", {31'd0, bus.write}, 0);
      repeat (HALF) @(negedge clk);
   endtask

   initial begin
      int base;
      bus.ss = 1'b1;
      bus.sck = 1'b0;
      bus.mosi = 1'b0;
      bus.read_value = 8'h00;
      seed_b = 8'($urandom);
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      repeat (3) @(negedge clk);
      check("rst_outputs",
            {bus.miso, bus.write, bus.new_req, bus.in_transaction,
             bus.reg_addr, bus.write_value}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      txn('{8'hC0, 8'h10, 8'hAA, 8'h55}, 0);
      txn('{8'h80, 8'h20, 8'h3C}, 0);
      txn('{8'h00, 8'h20, 8'h00, 8'h00, 8'h00}, 0);
      txn('{8'hC0, 8'hFF, 8'h01, 8'h02}, 0);
      txn('{8'hC0, 8'h05}, 4);
      txn('{8'hC0, 8'h06, 8'h11}, 0);
      txn('{8'h00, 8'h06, 8'h00}, 0);
      txn('{8'h80, 8'h30, 8'h11, 8'h22}, 0);

      chk_miso = 1'b0;
      bus.ss = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_byte(8'hC0, 8);
      spi_byte(8'h05, 8);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_addr", {24'd0, bus.reg_addr}, 0);
      check("midrst_flags",
            {bus.miso, bus.write, bus.new_req, bus.in_transaction}, 0);
      check("midrst_wval", {24'd0, bus.write_value}, 0);
      rst = 1'b0;
      base = nreq;
      spi_byte(8'h77, 8);
      spi_byte(8'h99, 8);
      repeat (2 * HALF) @(negedge clk);
      check("midrst_no_req", nreq - base, 0);
      bus.ss = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      chk_miso = 1'b1;
      txn('{8'hC0, 8'h40, 8'h5A}, 0);
      txn('{8'h40, 8'h40, 8'h00, 8'h00}, 0);

      for (int t = 0; t < 30; t++) begin
         bq_t b;
         int  len;
         len = 2 + $urandom_range(0, 4);
         b.push_back(8'($urandom));
         b.push_back(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom));
         for (int k = 2; k < len; k++) b.push_back(8'($urandom));
         txn(b, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0);
      end

      repeat (20) @(negedge clk);
      check("req_queue_empty", exp_req.size(), 0);
      check("miso_queue_empty", exp_miso.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
